// File: rtl/tick_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// tick_timer_ctrl_if
//   Configuration handshake between a controller and tick_timer_ctrl.
//   The requester drives cfg_valid with cfg_div/cfg_count and holds them
//   until it sees cfg_ready. The timer only raises cfg_ready while idle.
//
//   cfg_valid  master -> slave  config request
//   cfg_div    master -> slave  tick period in sysclk cycles (legal >= 2)
//   cfg_count  master -> slave  ticks per run, 0 selects periodic mode
//   cfg_ready  slave -> master  timer can accept a config this cycle
// ---------------------------------------------------------------------------
interface tick_timer_ctrl_if #(
  parameter int CNT_W    = 32,
  parameter int REPEAT_W = 16
) ();
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CNT_W-1:0]    cfg_div;
  logic [REPEAT_W-1:0] cfg_count;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/tick_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tick_timer_ctrl
//   Programmable tick scheduler. A single sysclk-domain counter produces a
//   one-cycle tick enable every div cycles and a slow clock that toggles on
//   every tick. Runs are either one-shot (count ticks, then o_done) or
//   periodic (count == 0), with start / pause / stop sequencing.
//
//   sysclk       system clock, rising edge
//   i_rst        synchronous active-high reset
//   cfg          config handshake (slave side), accepted only while idle
//   i_start      start from idle, or resume from pause
//   i_pause      freeze a running timer
//   i_stop       abort to idle (highest priority)
//   o_tick       registered single-cycle tick enable
//   o_clk        slow clock, toggles on each tick (period 2*div)
//   o_busy       running or paused
//   o_paused     paused
//   o_done       registered pulse alongside the last tick of a one-shot run
//   o_cfg_err    registered pulse after a rejected config (div < 2)
//   o_tick_cnt   ticks issued since the last start
// ---------------------------------------------------------------------------
module tick_timer_ctrl #(
  parameter int CNT_W       = 32,
  parameter int REPEAT_W    = 16,
  parameter int DEFAULT_DIV = 600000
) (
  input  logic                sysclk,
  input  logic                i_rst,
  tick_timer_ctrl_if.slave    cfg,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic                o_tick,
  output logic                o_clk,
  output logic                o_busy,
  output logic                o_paused,
  output logic                o_done,
  output logic                o_cfg_err,
  output logic [REPEAT_W-1:0] o_tick_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t              state_reg;
  state_t              state_next;

  logic [CNT_W-1:0]    div_reg;
  logic [REPEAT_W-1:0] count_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [REPEAT_W-1:0] tick_cnt_reg;
  logic                tick_reg;
  logic                clk_reg;
  logic                done_reg;
  logic                cfg_err_reg;

  logic [REPEAT_W-1:0] tick_cnt_inc;
  logic                terminal;
  logic                last_tick;
  logic                cfg_accept;

  assign tick_cnt_inc = tick_cnt_reg + REPEAT_W'(1);
  // Counter sits on its final value of the period; the next counting edge ticks.
  assign terminal     = (cnt_reg == (div_reg - CNT_W'(1)));
  // The tick about to be issued is the last one of a one-shot run.
  assign last_tick    = (count_reg != '0) && (tick_cnt_inc == count_reg);
  assign cfg_accept   = cfg.cfg_valid && (state_reg == ST_IDLE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Commands that make no sense in a state are dropped
  // before priority is applied, so i_stop/i_pause never block a start in idle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_stop)                      state_next = ST_IDLE;
        else if (i_pause)                state_next = ST_PAUSE;
        else if (terminal && last_tick)  state_next = ST_IDLE;
      end
      ST_PAUSE: begin
        if (i_stop)                      state_next = ST_IDLE;
        else if (!i_pause && i_start)    state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cfg.cfg_ready = 1'b0;
    o_busy        = 1'b0;
    o_paused      = 1'b0;
    case (state_reg)
      ST_IDLE:  cfg.cfg_ready = 1'b1;
      ST_RUN:   o_busy        = 1'b1;
      ST_PAUSE: begin
        o_busy   = 1'b1;
        o_paused = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: config registers, period counter, tick/clock/pulse outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      div_reg      <= CNT_W'(DEFAULT_DIV);
      count_reg    <= '0;
      cnt_reg      <= '0;
      tick_cnt_reg <= '0;
      tick_reg     <= 1'b0;
      clk_reg      <= 1'b0;
      done_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      tick_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;

      if (cfg_accept) begin
        if (cfg.cfg_div >= CNT_W'(2)) begin
          div_reg   <= cfg.cfg_div;
          count_reg <= cfg.cfg_count;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            cnt_reg      <= '0;
            tick_cnt_reg <= '0;
            clk_reg      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            cnt_reg <= '0;
            clk_reg <= 1'b0;
          end else if (i_pause) begin
            // Freeze everything; a tick due on this edge waits for resume.
          end else if (terminal) begin
            cnt_reg      <= '0;
            tick_reg     <= 1'b1;
            clk_reg      <= ~clk_reg;
            tick_cnt_reg <= tick_cnt_inc;
            done_reg     <= last_tick;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_PAUSE: begin
          // Resume edge does not count; only stop changes the datapath here.
          if (i_stop) begin
            cnt_reg <= '0;
            clk_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tick     = tick_reg;
  assign o_clk      = clk_reg;
  assign o_done     = done_reg;
  assign o_cfg_err  = cfg_err_reg;
  assign o_tick_cnt = tick_cnt_reg;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
module tb_tick_timer_ctrl;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // DUT A: full-size counters, default parameters
  logic        start_a, pause_a, stop_a;
  logic        tick_a, clk_a, busy_a, paused_a, done_a, err_a;
  logic [15:0] tcnt_a;

  // DUT B: 4-bit tick counter and short default period for wrap / reset checks
  logic        start_b, pause_b, stop_b;
  logic        tick_b, clk_b, busy_b, paused_b, done_b, err_b;
  logic [3:0]  tcnt_b;

  tick_timer_ctrl_if #(.CNT_W(32), .REPEAT_W(16)) cfg_a ();
  tick_timer_ctrl_if #(.CNT_W(32), .REPEAT_W(4))  cfg_b ();

  tick_timer_ctrl dut_a (
    .sysclk     (sysclk),
    .i_rst      (rst),
    .cfg        (cfg_a),
    .i_start    (start_a),
    .i_pause    (pause_a),
    .i_stop     (stop_a),
    .o_tick     (tick_a),
    .o_clk      (clk_a),
    .o_busy     (busy_a),
    .o_paused   (paused_a),
    .o_done     (done_a),
    .o_cfg_err  (err_a),
    .o_tick_cnt (tcnt_a)
  );

  tick_timer_ctrl #(.CNT_W(32), .REPEAT_W(4), .DEFAULT_DIV(6)) dut_b (
    .sysclk     (sysclk),
    .i_rst      (rst),
    .cfg        (cfg_b),
    .i_start    (start_b),
    .i_pause    (pause_b),
    .i_stop     (stop_b),
    .o_tick     (tick_b),
    .o_clk      (clk_b),
    .o_busy     (busy_b),
    .o_paused   (paused_b),
    .o_done     (done_b),
    .o_cfg_err  (err_b),
    .o_tick_cnt (tcnt_b)
  );

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cfg_load_a(input logic [31:0] d, input logic [15:0] c);
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_div   = d;
    cfg_a.cfg_count = c;
    step();
    cfg_a.cfg_valid = 1'b0;
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({tick_a, clk_a, busy_a, paused_a, done_a, err_a, cfg_a.cfg_ready} !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_a got tick/clk/busy/paused/done/err/ready=%b expected=0000001",
               {tick_a, clk_a, busy_a, paused_a, done_a, err_a, cfg_a.cfg_ready});
    end
    checks++;
    if (tcnt_a !== 16'd0) begin
      failures++;
      $display("FAIL reset_tcnt_a got=%0d expected=0", tcnt_a);
    end
    checks++;
    if ({tick_b, clk_b, busy_b, paused_b, done_b, err_b, cfg_b.cfg_ready, tcnt_b} !== 11'b0000001_0000) begin
      failures++;
      $display("FAIL reset_b got=%b expected=00000010000",
               {tick_b, clk_b, busy_b, paused_b, done_b, err_b, cfg_b.cfg_ready, tcnt_b});
    end
    rst = 1'b0;
    step();
  endtask

  // div=4 count=3: ticks after E4, E8, E12; done with the third
  task automatic test_oneshot();
    logic       exp_tick, exp_clk, exp_done;
    logic [15:0] exp_cnt;
    cfg_load_a(32'd4, 16'd3);
    checks++;
    if (err_a !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_cfg_err got=%b expected=0", err_a);
    end
    start_pulse_a();
    checks++;
    if ({busy_a, cfg_a.cfg_ready, tick_a} !== 3'b100) begin
      failures++;
      $display("FAIL oneshot_start got busy/ready/tick=%b expected=100", {busy_a, cfg_a.cfg_ready, tick_a});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_tick = (k % 4 == 0);
      exp_clk  = ((k >= 4) && (k < 8)) || (k >= 12);
      exp_done = (k == 12);
      exp_cnt  = 16'(k / 4);
      checks++;
      if ({tick_a, clk_a, done_a} !== {exp_tick, exp_clk, exp_done}) begin
        failures++;
        $display("FAIL oneshot_outputs edge=%0d got tick/clk/done=%b expected=%b",
                 k, {tick_a, clk_a, done_a}, {exp_tick, exp_clk, exp_done});
      end
      checks++;
      if (tcnt_a !== exp_cnt) begin
        failures++;
        $display("FAIL oneshot_tcnt edge=%0d got=%0d expected=%0d", k, tcnt_a, exp_cnt);
      end
    end
    checks++;
    if ({cfg_a.cfg_ready, busy_a} !== 2'b10) begin
      failures++;
      $display("FAIL oneshot_end_state got ready/busy=%b expected=10", {cfg_a.cfg_ready, busy_a});
    end
    step();
    checks++;
    if ({tick_a, done_a, clk_a, tcnt_a} !== {1'b0, 1'b0, 1'b1, 16'd3}) begin
      failures++;
      $display("FAIL oneshot_hold got tick/done/clk=%b tcnt=%0d expected 001 tcnt=3",
               {tick_a, done_a, clk_a}, tcnt_a);
    end
  endtask

  // div=1 rejected; config held during RUN is only taken on the first IDLE edge
  task automatic test_cfg();
    logic exp_tick;
    cfg_load_a(32'd1, 16'd0);
    checks++;
    if (err_a !== 1'b1) begin
      failures++;
      $display("FAIL cfg_err_pulse got=%b expected=1", err_a);
    end
    step();
    checks++;
    if (err_a !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err_single got=%b expected=0", err_a);
    end
    // Still div=4 count=3 from before: ticks at 4, 8, 12
    start_pulse_a();
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_div   = 32'd6;
    cfg_a.cfg_count = 16'd1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_tick = (k % 4 == 0);
      checks++;
      if ({tick_a, err_a, cfg_a.cfg_ready} !== {exp_tick, 1'b0, (k == 12)}) begin
        failures++;
        $display("FAIL cfg_run_hold edge=%0d got tick/err/ready=%b expected=%b",
                 k, {tick_a, err_a, cfg_a.cfg_ready}, {exp_tick, 1'b0, (k == 12)});
      end
    end
    step();  // first IDLE edge takes the held config
    cfg_a.cfg_valid = 1'b0;
    start_pulse_a();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if ({tick_a, done_a} !== {(k == 6), (k == 6)}) begin
        failures++;
        $display("FAIL cfg_late_latch edge=%0d got tick/done=%b expected=%b",
                 k, {tick_a, done_a}, {(k == 6), (k == 6)});
      end
    end
  endtask

  // Periodic div=5: pause at E8, resume at E18, next tick after E21
  task automatic test_pause();
    logic exp_tick, exp_paused, exp_clk;
    cfg_load_a(32'd5, 16'd0);
    start_pulse_a();
    for (int k = 1; k <= 21; k++) begin
      if (k == 8)  pause_a = 1'b1;
      if (k == 18) start_a = 1'b1;
      step();
      pause_a = 1'b0;
      start_a = 1'b0;
      exp_tick   = (k == 5) || (k == 21);
      exp_paused = (k >= 8) && (k < 18);
      exp_clk    = (k >= 5) && (k < 21);
      checks++;
      if ({tick_a, paused_a, busy_a, clk_a} !== {exp_tick, exp_paused, 1'b1, exp_clk}) begin
        failures++;
        $display("FAIL pause_outputs edge=%0d got tick/paused/busy/clk=%b expected=%b",
                 k, {tick_a, paused_a, busy_a, clk_a}, {exp_tick, exp_paused, 1'b1, exp_clk});
      end
    end
    checks++;
    if (tcnt_a !== 16'd2) begin
      failures++;
      $display("FAIL pause_tcnt got=%0d expected=2", tcnt_a);
    end
    stop_a = 1'b1;
    step();
    stop_a = 1'b0;
  endtask

  // Periodic div=4: stop on terminal edge E8 suppresses the tick
  task automatic test_stop_terminal();
    logic exp_tick, exp_clk;
    cfg_load_a(32'd4, 16'd0);
    start_pulse_a();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) stop_a = 1'b1;
      step();
      stop_a = 1'b0;
      exp_tick = (k == 4);
      exp_clk  = (k >= 4) && (k < 8);
      checks++;
      if ({tick_a, clk_a, busy_a, done_a} !== {exp_tick, exp_clk, (k < 8), 1'b0}) begin
        failures++;
        $display("FAIL stop_outputs edge=%0d got tick/clk/busy/done=%b expected=%b",
                 k, {tick_a, clk_a, busy_a, done_a}, {exp_tick, exp_clk, (k < 8), 1'b0});
      end
    end
    checks++;
    if ({tcnt_a, cfg_a.cfg_ready} !== {16'd1, 1'b1}) begin
      failures++;
      $display("FAIL stop_readout got tcnt=%0d ready=%b expected tcnt=1 ready=1", tcnt_a, cfg_a.cfg_ready);
    end
  endtask

  // Start ignored in RUN; pause beats start; stop beats pause; idle ignores pause/stop
  task automatic test_cmd_priority();
    start_pulse_a();
    step();
    step();
    start_a = 1'b1;   // E3: must not restart the period
    step();
    start_a = 1'b0;
    step();           // E4
    checks++;
    if (tick_a !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run got tick=%b expected=1", tick_a);
    end
    pause_a = 1'b1;
    start_a = 1'b1;
    step();
    pause_a = 1'b0;
    start_a = 1'b0;
    checks++;
    if ({busy_a, paused_a} !== 2'b11) begin
      failures++;
      $display("FAIL pause_over_start got busy/paused=%b expected=11", {busy_a, paused_a});
    end
    stop_a  = 1'b1;
    pause_a = 1'b1;
    step();
    stop_a  = 1'b0;
    pause_a = 1'b0;
    checks++;
    if ({busy_a, paused_a, cfg_a.cfg_ready, clk_a} !== 4'b0010) begin
      failures++;
      $display("FAIL stop_over_pause got busy/paused/ready/clk=%b expected=0010",
               {busy_a, paused_a, cfg_a.cfg_ready, clk_a});
    end
    pause_a = 1'b1;
    step();
    stop_a  = 1'b1;
    pause_a = 1'b0;
    step();
    stop_a  = 1'b0;
    checks++;
    if ({busy_a, paused_a, cfg_a.cfg_ready} !== 3'b001) begin
      failures++;
      $display("FAIL idle_ignores got busy/paused/ready=%b expected=001", {busy_a, paused_a, cfg_a.cfg_ready});
    end
  endtask

  // 4-bit tick counter, div=2 periodic: 17 ticks -> ... 15, 0, 1
  task automatic test_wrap();
    logic [3:0] exp_cnt;
    cfg_b.cfg_valid = 1'b1;
    cfg_b.cfg_div   = 32'd2;
    cfg_b.cfg_count = 4'd0;
    step();
    cfg_b.cfg_valid = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      step();
      exp_cnt = 4'((k / 2) % 16);
      checks++;
      if ({tick_b, done_b, tcnt_b} !== {(k % 2 == 0), 1'b0, exp_cnt}) begin
        failures++;
        $display("FAIL wrap edge=%0d got tick=%b done=%b tcnt=%0d expected tick=%b done=0 tcnt=%0d",
                 k, tick_b, done_b, tcnt_b, (k % 2 == 0), exp_cnt);
      end
    end
  endtask

  // Reset mid-run, then confirm the default period (6) is back in force
  task automatic test_reset_midrun();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({tick_b, clk_b, busy_b, paused_b, done_b, err_b, cfg_b.cfg_ready, tcnt_b} !== 11'b0000001_0000) begin
      failures++;
      $display("FAIL midrun_reset got=%b expected=00000010000",
               {tick_b, clk_b, busy_b, paused_b, done_b, err_b, cfg_b.cfg_ready, tcnt_b});
    end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if ({tick_b, done_b} !== {(k == 6), 1'b0}) begin
        failures++;
        $display("FAIL default_div edge=%0d got tick/done=%b expected=%b",
                 k, {tick_b, done_b}, {(k == 6), 1'b0});
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; pause_a = 1'b0; stop_a = 1'b0;
    start_b = 1'b0; pause_b = 1'b0; stop_b = 1'b0;
    cfg_a.cfg_valid = 1'b0; cfg_a.cfg_div = '0; cfg_a.cfg_count = '0;
    cfg_b.cfg_valid = 1'b0; cfg_b.cfg_div = '0; cfg_b.cfg_count = '0;

    test_reset();
    test_oneshot();
    test_cfg();
    test_pause();
    test_stop_terminal();
    test_cmd_priority();
    test_wrap();
    test_reset_midrun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/tick_timer_ctrl.md
Name: tick_timer_ctrl

Overview:
- Programmable tick scheduler for the prescaler datapath: one sysclk-domain counter generates single-cycle tick enables and a toggled slow clock at a run-time configurable period.
- Supports a config handshake, start/pause/stop sequencing, and one-shot (N ticks) or periodic mode.
- Sits between control logic (buttons/FSMs) and the consumers of slow timing enables.

Parameters:
- CNT_W, 32, width of the period counter and of i_cfg_div.
- REPEAT_W, 16, width of tick count and of i_cfg_count.
- DEFAULT_DIV, 600000, tick period in sysclk cycles loaded at reset.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_cfg_valid  in  1  config request.
- o_cfg_ready  out  1  high only in IDLE; combinational from state.
- i_cfg_div  in  CNT_W  tick period in cycles; legal values are 2..2^CNT_W-1.
- i_cfg_count  in  REPEAT_W  ticks per run; 0 means periodic.
- i_start  in  1  start from IDLE, or resume from PAUSE.
- i_pause  in  1  freeze a running timer.
- i_stop  in  1  abort to IDLE.
- o_tick  out  1  single-cycle tick enable.
- o_clk  out  1  toggles on every tick; period is 2*div.
- o_busy  out  1  high in RUN or PAUSE.
- o_paused  out  1  high in PAUSE.
- o_done  out  1  single-cycle pulse at the end of a one-shot run.
- o_cfg_err  out  1  single-cycle pulse on a rejected config.
- o_tick_cnt  out  REPEAT_W  ticks issued since last start.

Behaviour:
- Reset (sampled at an edge): state=IDLE, div=DEFAULT_DIV, count=0, cnt=0. o_tick, o_clk, o_done, o_cfg_err, o_tick_cnt, o_busy and o_paused are all 0. o_cfg_ready=1 from the following cycle. A reset mid-run aborts immediately with no o_done.
- States: IDLE, RUN, PAUSE.
- Command priority at any edge: i_stop > i_pause > i_start. Commands that are illegal for the current state are ignored.
- Config:
  - Accepted on an edge with i_cfg_valid && o_cfg_ready.
  - If i_cfg_div >= 2, div and count are latched.
  - Otherwise (div 0 or 1) the registers are unchanged and o_cfg_err pulses high for the following cycle.
  - i_cfg_valid outside IDLE is not accepted and produces no error; the requester holds valid until ready.
- IDLE -> RUN on the edge sampling i_start: cnt=0, o_tick_cnt=0, o_clk=0.
- RUN counting:
  - Each edge increments cnt.
  - On the edge where cnt==div-1: cnt=0, o_tick=1 for the following cycle, o_clk toggles, o_tick_cnt increments.
  - The first tick therefore lands on the div-th edge after the start edge; subsequent ticks are every div edges.
- One-shot completion (count!=0): on the tick edge where o_tick_cnt+1==count, o_done is asserted in the same cycle as that final o_tick. Next state is IDLE; o_clk and o_tick_cnt hold their values.
- Periodic mode (count==0): runs until stopped; o_tick_cnt wraps from 2^REPEAT_W-1 to 0.
- RUN -> PAUSE on i_pause:
  - cnt does not increment on that edge, even if cnt==div-1; the tick is deferred.
  - o_clk and o_tick_cnt are frozen.
- PAUSE -> RUN on i_start: no increment on the resume edge; counting continues from the frozen cnt.
- RUN/PAUSE -> IDLE on i_stop:
  - cnt=0, o_clk=0, no o_tick and no o_done on that edge, even if it coincides with a terminal edge.
  - o_tick_cnt holds its value for readout.
- i_start while in RUN is ignored. i_pause or i_stop while in IDLE is ignored.
- Registers: o_tick, o_done and o_cfg_err are registered, never combinational. o_busy and o_paused are decoded from state.

Test Plan:
- Reset, then config div=4 count=3, then start at edge E0 -> o_tick after E4, E8 and E12; o_clk goes 1,0,1; o_done coincides with the third tick; o_tick_cnt=3; o_cfg_ready=1 after E12.
- Config div=1 -> o_cfg_err pulses one cycle and div stays 4. Assert i_cfg_valid during RUN -> o_cfg_ready=0 and no latch; the config is accepted on the first IDLE edge.
- Periodic, div=5, start at E0 -> tick after E5. Pause sampled at E8 (cnt=2), held 10 cycles, resume sampled at E18 -> next tick after E21; no tick while paused.
- Periodic, div=4, i_stop on a terminal edge E8 -> no o_tick, no o_done; o_clk=0; state IDLE; o_tick_cnt=1.
- i_pause and i_start together in RUN -> PAUSE. i_stop and i_pause together in PAUSE -> IDLE.
- REPEAT_W=4, periodic, div=2, run 17 ticks -> o_tick_cnt goes 15, 0, 1. Then pulse i_rst mid-run -> all outputs 0, div=DEFAULT_DIV, o_cfg_ready=1.
